// File: rtl/approx_err_sweeper_pkg.sv
`default_nettype none
// approx_err_pkg: sweeper FSM state type and the width helpers that size the
// product, error, sum and count buses from the operand width.
package approx_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // One extra bit so approx - exact never overflows for any product pair.
  function automatic int err_w(input int w);
    return 2 * w + 1;
  endfunction

  // 2^(2w) samples of at most 2^(2w) magnitude each, plus a sign bit.
  function automatic int sum_w(input int w);
    return 4 * w + 2;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/approx_err_sweeper_if.sv
`default_nettype none
// approx_err_sweeper_if: sweep control, operand/product exchange with the external
// multipliers, and the accumulated error statistics.
interface approx_err_sweeper_if #(
  parameter int WIDTH = 8
);
  import approx_err_pkg::*;

  logic                            i_start;
  logic                            o_busy;
  logic                            o_done;
  logic [WIDTH-1:0]                o_a;
  logic [WIDTH-1:0]                o_b;
  logic                            o_valid;
  logic [prod_w(WIDTH)-1:0]        i_exact;
  logic [prod_w(WIDTH)-1:0]        i_approx;
  logic signed [sum_w(WIDTH)-1:0]  o_sum_err;
  logic [sum_w(WIDTH)-1:0]         o_sum_abs_err;
  logic [err_w(WIDTH)-1:0]         o_max_abs_err;
  logic [WIDTH-1:0]                o_max_a;
  logic [WIDTH-1:0]                o_max_b;
  logic [cnt_w(WIDTH)-1:0]         o_err_cnt;
  logic [cnt_w(WIDTH)-1:0]         o_sample_cnt;

  modport slave (
    input  i_start, i_exact, i_approx,
    output o_busy, o_done, o_a, o_b, o_valid,
           o_sum_err, o_sum_abs_err, o_max_abs_err,
           o_max_a, o_max_b, o_err_cnt, o_sample_cnt
  );

  modport master (
    output i_start, i_exact, i_approx,
    input  o_busy, o_done, o_a, o_b, o_valid,
           o_sum_err, o_sum_abs_err, o_max_abs_err,
           o_max_a, o_max_b, o_err_cnt, o_sample_cnt
  );

endinterface
`default_nettype wire

// File: rtl/approx_err_sweeper_err_accum.sv
`default_nettype none
// err_accum: per-sample error (approx - exact), its magnitude, running sums,
// first-occurrence worst case with its operands, and sample/error counters.
module err_accum
  import approx_err_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SIGNED_MODE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           cap_en,
  input  logic [WIDTH-1:0]               cap_a,
  input  logic [WIDTH-1:0]               cap_b,
  input  logic [prod_w(WIDTH)-1:0]       exact,
  input  logic [prod_w(WIDTH)-1:0]       approx,
  output logic signed [sum_w(WIDTH)-1:0] sum_err,
  output logic [sum_w(WIDTH)-1:0]        sum_abs_err,
  output logic [err_w(WIDTH)-1:0]        max_abs_err,
  output logic [WIDTH-1:0]               max_a,
  output logic [WIDTH-1:0]               max_b,
  output logic [cnt_w(WIDTH)-1:0]        err_cnt,
  output logic [cnt_w(WIDTH)-1:0]        sample_cnt
);

  localparam int PW = prod_w(WIDTH);
  localparam int EW = err_w(WIDTH);
  localparam int SW = sum_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  logic                 ext_exact;
  logic                 ext_approx;
  logic signed [EW-1:0] err;
  logic [EW-1:0]        abs_err;
  logic [SW-1:0]        err_wide;
  logic [SW-1:0]        abs_wide;

  // Unsigned products are zero-extended, signed ones sign-extended, before the subtract.
  assign ext_exact  = (SIGNED_MODE != 0) & exact[PW-1];
  assign ext_approx = (SIGNED_MODE != 0) & approx[PW-1];
  assign err        = $signed({ext_approx, approx}) - $signed({ext_exact, exact});
  assign abs_err    = err[EW-1] ? $unsigned(-err) : $unsigned(err);
  assign err_wide   = {{(SW-EW){err[EW-1]}}, err};
  assign abs_wide   = {{(SW-EW){1'b0}}, abs_err};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_err     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_a       <= '0;
      max_b       <= '0;
      err_cnt     <= '0;
      sample_cnt  <= '0;
    end else if (cap_en) begin
      sum_err     <= sum_err + err_wide;
      sum_abs_err <= sum_abs_err + abs_wide;
      // Strictly greater keeps the earliest pair on ties.
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
        max_a       <= cap_a;
        max_b       <= cap_b;
      end
      if (err != '0) begin
        err_cnt <= err_cnt + CW'(1);
      end
      sample_cnt  <= sample_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/approx_err_sweeper.sv
`default_nettype none
// approx_err_sweeper: walks every (a,b) operand pair once, aligns the returned
// products through a LATENCY-deep valid pipeline and feeds err_accum.
module approx_err_sweeper
  import approx_err_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SIGNED_MODE = 1,
  parameter int LATENCY     = 1
) (
  input logic                 i_clk,
  input logic                 i_rst,
  approx_err_sweeper_if.slave bus
);

  localparam logic [WIDTH-1:0] OP_MIN = (SIGNED_MODE != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
  localparam logic [WIDTH-1:0] OP_MAX = (SIGNED_MODE != 0) ? {1'b0, {(WIDTH-1){1'b1}}} : '1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             last;
  logic             clr_acc;
  logic             drain_end;
  logic             cap_en;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;

  assign last = (a == OP_MAX) && (b == OP_MAX);

  always_comb begin
    state_nx = state;
    clr_acc  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.i_start) begin
          state_nx = SWEEP;
          clr_acc  = 1'b1;
        end
      end
      SWEEP: begin
        if (last) begin
          state_nx = (LATENCY == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
    end else begin
      state <= state_nx;
      if (clr_acc) begin
        a <= OP_MIN;
        b <= OP_MIN;
      end else if (state == SWEEP && !last) begin
        // Raw bit patterns wrap MAX -> MIN in both signed and unsigned modes.
        b <= b + 1'b1;
        if (b == OP_MAX) begin
          a <= a + 1'b1;
        end
      end
    end
  end

  assign bus.o_busy  = (state == SWEEP) || (state == DRAIN);
  assign bus.o_done  = (state == DONE);
  assign bus.o_valid = (state == SWEEP);
  assign bus.o_a     = a;
  assign bus.o_b     = b;

  generate
    if (LATENCY > 0) begin : g_pipe
      logic [LATENCY-1:0] vpipe;
      logic [WIDTH-1:0]   apipe [LATENCY];
      logic [WIDTH-1:0]   bpipe [LATENCY];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          vpipe <= '0;
          for (int i = 0; i < LATENCY; i++) begin
            apipe[i] <= '0;
            bpipe[i] <= '0;
          end
        end else begin
          vpipe[0] <= (state == SWEEP);
          apipe[0] <= a;
          bpipe[0] <= b;
          for (int i = 1; i < LATENCY; i++) begin
            vpipe[i] <= vpipe[i-1];
            apipe[i] <= apipe[i-1];
            bpipe[i] <= bpipe[i-1];
          end
        end
      end

      assign cap_en    = vpipe[LATENCY-1];
      assign cap_a     = apipe[LATENCY-1];
      assign cap_b     = bpipe[LATENCY-1];
      // Empty after this edge once only the oldest stage still holds a sample.
      assign drain_end = ((vpipe << 1) == '0);
    end else begin : g_nopipe
      assign cap_en    = (state == SWEEP);
      assign cap_a     = a;
      assign cap_b     = b;
      assign drain_end = 1'b1;
    end
  endgenerate

  err_accum #(
    .WIDTH       (WIDTH),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_err_accum (
    .clk         (i_clk),
    .rst         (i_rst),
    .clear       (clr_acc),
    .cap_en      (cap_en),
    .cap_a       (cap_a),
    .cap_b       (cap_b),
    .exact       (bus.i_exact),
    .approx      (bus.i_approx),
    .sum_err     (bus.o_sum_err),
    .sum_abs_err (bus.o_sum_abs_err),
    .max_abs_err (bus.o_max_abs_err),
    .max_a       (bus.o_max_a),
    .max_b       (bus.o_max_b),
    .err_cnt     (bus.o_err_cnt),
    .sample_cnt  (bus.o_sample_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_approx_err_sweeper.sv
`default_nettype none
// tb_approx_err_sweeper: four sweeper instances (W2 signed, W4 unsigned, W8 signed
// at LATENCY 0 and 3 against a Mitchell log multiplier) checked against a sweep model.
module tb_approx_err_sweeper;

  localparam int K_EXACT = 0;
  localparam int K_PLUS1 = 1;
  localparam int K_LSB   = 2;
  localparam int K_MITCH = 3;

  typedef struct {
    longint se;
    longint sa;
    longint mx;
    longint ma;
    longint mb;
    longint ec;
    longint sc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int p1       = 0;
  int k4 = 0, k8a = 0, k8b = 0, last4_a = -1, last4_b = -1;

  approx_err_sweeper_if #(.WIDTH(2)) if2 ();
  approx_err_sweeper_if #(.WIDTH(4)) if4 ();
  approx_err_sweeper_if #(.WIDTH(8)) if8a ();
  approx_err_sweeper_if #(.WIDTH(8)) if8b ();

  approx_err_sweeper #(.WIDTH(2), .SIGNED_MODE(1), .LATENCY(1)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2));
  approx_err_sweeper #(.WIDTH(4), .SIGNED_MODE(0), .LATENCY(2)) u4 (.i_clk(clk), .i_rst(rst), .bus(if4));
  approx_err_sweeper #(.WIDTH(8), .SIGNED_MODE(1), .LATENCY(0)) u8a (.i_clk(clk), .i_rst(rst), .bus(if8a));
  approx_err_sweeper #(.WIDTH(8), .SIGNED_MODE(1), .LATENCY(3)) u8b (.i_clk(clk), .i_rst(rst), .bus(if8b));

  function automatic int opv(input int raw, input int w, input int s);
    if (s != 0 && ((raw >> (w - 1)) & 1) == 1) return raw - (1 << w);
    return raw;
  endfunction

  function automatic int op_raw(input int idx, input int w, input int s);
    return (((s != 0) ? (1 << (w - 1)) : 0) + idx) & ((1 << w) - 1);
  endfunction

  function automatic int mitchell(input int x, input int y);
    int ax, ay, k1, k2, t, p;
    if (x == 0 || y == 0) return 0;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    k1 = 0;
    while ((ax >> (k1 + 1)) != 0) k1++;
    k2 = 0;
    while ((ay >> (k2 + 1)) != 0) k2++;
    t = ((ax - (1 << k1)) << k2) + ((ay - (1 << k2)) << k1);
    if (t < (1 << (k1 + k2))) p = (1 << (k1 + k2)) + t;
    else p = 2 * t;
    return ((x < 0) != (y < 0)) ? -p : p;
  endfunction

  function automatic int approx_of(input int kind, input int x, input int y);
    case (kind)
      K_EXACT: return x * y;
      K_PLUS1: return x * y + 1;
      K_LSB:   return (x * y) & ~1;
      default: return mitchell(x, y);
    endcase
  endfunction

  function automatic res_t model(input int w, input int s, input int kind);
    res_t r;
    int ar, br, x, y, e, ae;
    r = '{default: 0};
    for (int k = 0; k < (1 << (2 * w)); k++) begin
      ar = op_raw(k >> w, w, s);
      br = op_raw(k & ((1 << w) - 1), w, s);
      x  = opv(ar, w, s);
      y  = opv(br, w, s);
      e  = approx_of(kind, x, y) - x * y;
      ae = (e < 0) ? -e : e;
      r.se += e;
      r.sa += ae;
      r.sc += 1;
      if (e != 0) r.ec += 1;
      if (ae > r.mx) begin
        r.mx = ae;
        r.ma = ar;
        r.mb = br;
      end
    end
    return r;
  endfunction

  // External multipliers: product valid LATENCY cycles after the operands.
  always @(posedge clk) begin
    if2.i_exact  <= 4'(opv(int'(if2.o_a), 2, 1) * opv(int'(if2.o_b), 2, 1));
    if2.i_approx <= 4'(opv(int'(if2.o_a), 2, 1) * opv(int'(if2.o_b), 2, 1) + p1);
  end

  logic [7:0] e4 [2];
  logic [7:0] x4 [2];
  always @(posedge clk) begin
    e4[0] <= 8'(int'(if4.o_a) * int'(if4.o_b));
    x4[0] <= 8'(approx_of(K_LSB, int'(if4.o_a), int'(if4.o_b)));
    e4[1] <= e4[0];
    x4[1] <= x4[0];
  end
  assign if4.i_exact  = e4[1];
  assign if4.i_approx = x4[1];

  assign if8a.i_exact  = 16'(opv(int'(if8a.o_a), 8, 1) * opv(int'(if8a.o_b), 8, 1));
  assign if8a.i_approx = 16'(mitchell(opv(int'(if8a.o_a), 8, 1), opv(int'(if8a.o_b), 8, 1)));

  logic [15:0] e8 [3];
  logic [15:0] x8 [3];
  always @(posedge clk) begin
    e8[0] <= 16'(opv(int'(if8b.o_a), 8, 1) * opv(int'(if8b.o_b), 8, 1));
    x8[0] <= 16'(mitchell(opv(int'(if8b.o_a), 8, 1), opv(int'(if8b.o_b), 8, 1)));
    for (int i = 1; i < 3; i++) begin
      e8[i] <= e8[i-1];
      x8[i] <= x8[i-1];
    end
  end
  assign if8b.i_exact  = e8[2];
  assign if8b.i_approx = x8[2];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic res_t dut_res(input int sel);
    res_t r;
    case (sel)
      0: r = '{if2.o_sum_err, if2.o_sum_abs_err, if2.o_max_abs_err, if2.o_max_a, if2.o_max_b, if2.o_err_cnt, if2.o_sample_cnt};
      1: r = '{if4.o_sum_err, if4.o_sum_abs_err, if4.o_max_abs_err, if4.o_max_a, if4.o_max_b, if4.o_err_cnt, if4.o_sample_cnt};
      2: r = '{if8a.o_sum_err, if8a.o_sum_abs_err, if8a.o_max_abs_err, if8a.o_max_a, if8a.o_max_b, if8a.o_err_cnt, if8a.o_sample_cnt};
      default: r = '{if8b.o_sum_err, if8b.o_sum_abs_err, if8b.o_max_abs_err, if8b.o_max_a, if8b.o_max_b, if8b.o_err_cnt, if8b.o_sample_cnt};
    endcase
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t g, input res_t e);
    chk({tag, "_sum_err"}, g.se, e.se);
    chk({tag, "_sum_abs_err"}, g.sa, e.sa);
    chk({tag, "_max_abs_err"}, g.mx, e.mx);
    chk({tag, "_max_a"}, g.ma, e.ma);
    chk({tag, "_max_b"}, g.mb, e.mb);
    chk({tag, "_err_cnt"}, g.ec, e.ec);
    chk({tag, "_sample_cnt"}, g.sc, e.sc);
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 0) ? if2.o_done : if4.o_done;
  endfunction

  task automatic go(input int sel);
    @(negedge clk);
    if (sel == 0) if2.i_start = 1'b1;
    else begin
      if4.i_start = 1'b1;
      k4 = 0;
    end
    @(negedge clk);
    if2.i_start = 1'b0;
    if4.i_start = 1'b0;
  endtask

  // n counts falling edges since the start request was driven.
  task automatic wait_done(input int sel, input int budget, output int n);
    n = 1;
    while (done_of(sel) == 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", longint'(done_of(sel)), 1);
  endtask

  // Operand stream: every valid cycle must carry the next pair in sweep order.
  task automatic stream_mon();
    forever begin
      @(negedge clk);
      if (if4.o_valid) begin
        chk("u4_stream_in_range", longint'(k4 < 256), 1);
        chk("u4_stream_a", if4.o_a, op_raw(k4 >> 4, 4, 0));
        chk("u4_stream_b", if4.o_b, op_raw(k4 & 15, 4, 0));
        last4_a = int'(if4.o_a);
        last4_b = int'(if4.o_b);
        k4++;
      end
      if (if8a.o_valid) begin
        chk("u8a_stream_in_range", longint'(k8a < 65536), 1);
        chk("u8a_stream_a", if8a.o_a, op_raw(k8a >> 8, 8, 1));
        chk("u8a_stream_b", if8a.o_b, op_raw(k8a & 255, 8, 1));
        k8a++;
      end
      if (if8b.o_valid) begin
        chk("u8b_stream_a", if8b.o_a, op_raw(k8b >> 8, 8, 1));
        chk("u8b_stream_b", if8b.o_b, op_raw(k8b & 255, 8, 1));
        k8b++;
      end
    end
  endtask

  initial begin
    res_t m, g, zero;
    int n, na, nb;
    zero = '{default: 0};
    if2.i_start = 1'b0;
    if4.i_start = 1'b0;
    if8a.i_start = 1'b0;
    if8b.i_start = 1'b0;
    fork
      stream_mon();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy4", if4.o_busy, 0);
    chk("rst_done4", if4.o_done, 0);
    chk("rst_valid8", if8a.o_valid, 0);
    chk("rst_a4", if4.o_a, 0);
    check_res("rst_w2", dut_res(0), zero);

    // Hand-computed pins for the model itself.
    m = model(2, 1, K_PLUS1);
    chk("model_w2_sum_err", m.se, 16);
    chk("model_w2_max_a", m.ma, 2);
    m = model(4, 0, K_LSB);
    chk("model_w4_sum_err", m.se, -64);
    chk("model_w4_err_cnt", m.ec, 64);
    chk("model_w4_max_a", m.ma, 1);
    chk("model_w4_max_b", m.mb, 1);

    p1 = 0;
    go(0);
    wait_done(0, 100, n);
    chk("w2_cycles", n, 18);
    check_res("w2_tied", dut_res(0), '{se: 0, sa: 0, mx: 0, ma: 0, mb: 0, ec: 0, sc: 16});

    p1 = 1;
    go(0);
    chk("w2_restart_done", if2.o_done, 0);
    wait_done(0, 100, n);
    check_res("w2_plus1", dut_res(0), '{se: 16, sa: 16, mx: 1, ma: 2, mb: 2, ec: 16, sc: 16});

    m = model(4, 0, K_LSB);
    go(1);
    repeat (40) @(negedge clk);
    if4.i_start = 1'b1;
    @(negedge clk);
    if4.i_start = 1'b0;
    wait_done(1, 400, n);
    check_res("w4_a", dut_res(1), m);
    chk("w4_stream_len", k4, 256);
    chk("w4_last_a", last4_a, 15);
    chk("w4_last_b", last4_b, 15);
    repeat (5) @(negedge clk);
    check_res("w4_hold", dut_res(1), m);
    chk("w4_hold_done", if4.o_done, 1);

    go(1);
    chk("w4_restart_done", if4.o_done, 0);
    chk("w4_restart_cnt", if4.o_sample_cnt, 0);
    chk("w4_restart_abs", if4.o_sum_abs_err, 0);
    wait_done(1, 400, n);
    chk("w4_cycles", n, 259);
    check_res("w4_b", dut_res(1), m);

    go(1);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("w4_rst_busy", if4.o_busy, 0);
    chk("w4_rst_done", if4.o_done, 0);
    chk("w4_rst_valid", if4.o_valid, 0);
    chk("w4_rst_a", if4.o_a, 0);
    chk("w4_rst_b", if4.o_b, 0);
    check_res("w4_rst", dut_res(1), zero);
    rst = 1'b0;
    go(1);
    wait_done(1, 400, n);
    check_res("w4_c", dut_res(1), m);

    @(negedge clk);
    if8a.i_start = 1'b1;
    if8b.i_start = 1'b1;
    k8a = 0;
    k8b = 0;
    n = 0;
    na = 0;
    nb = 0;
    while ((na == 0 || nb == 0) && n < 70000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if8a.i_start = 1'b0;
        if8b.i_start = 1'b0;
      end
      if (na == 0 && if8a.o_done) na = n;
      if (nb == 0 && if8b.o_done) nb = n;
    end
    chk("w8_l0_cycles", na, 65537);
    chk("w8_l3_cycles", nb, 65540);
    chk("w8_stream_len", k8a, 65536);
    m = model(8, 1, K_MITCH);
    chk("w8_model_samples", m.sc, 65536);
    check_res("w8_l0", dut_res(2), m);
    check_res("w8_l3", dut_res(3), m);
    g = dut_res(2);
    chk("w8_samples_lit", g.sc, 65536);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/approx_err_sweeper.md
APPROX_ERR_SWEEPER -- requirements
Module: approx_err_sweeper

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits (2..12).
REQ-002 SHALL have parameter SIGNED_MODE, default 1: 1 = two's-complement operands/products, 0 = unsigned.
REQ-003 SHALL have parameter LATENCY, default 1: cycles from o_valid to product-valid at i_exact/i_approx (0..4).
REQ-004 SHALL have port i_clk, input, 1: the single clock.
REQ-005 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_start, input, 1: sweep request, sampled on a rising edge of i_clk.
REQ-007 SHALL have port o_busy, output, 1: high in SWEEP or DRAIN.
REQ-008 SHALL have port o_done, output, 1: high in DONE; results valid and stable.
REQ-009 SHALL have ports o_a and o_b, output, WIDTH each: operands driven to the external exact and approximate multipliers.
REQ-010 SHALL have port o_valid, output, 1: o_a/o_b carry a live sample.
REQ-011 SHALL have ports i_exact and i_approx, input, 2*WIDTH each: products, sampled LATENCY cycles after o_valid.
REQ-012 SHALL have port o_sum_err, output, 4*WIDTH+2, signed: sum of (approx - exact).
REQ-013 SHALL have port o_sum_abs_err, output, 4*WIDTH+2: sum of |approx - exact|.
REQ-014 SHALL have port o_max_abs_err, output, 2*WIDTH+1: worst |error|.
REQ-015 SHALL have ports o_max_a and o_max_b, output, WIDTH each: operands giving o_max_abs_err.
REQ-016 SHALL have ports o_err_cnt and o_sample_cnt, output, 2*WIDTH+1 each: count of nonzero errors; count of samples.

Function
REQ-017 SHALL implement FSM IDLE -> SWEEP -> DRAIN -> DONE.
REQ-018 IDLE, or DONE, with i_start high: SHALL clear all accumulators, load a=b=MIN, go to SWEEP next cycle.
REQ-019 MIN/MAX SHALL be -2^(WIDTH-1)/2^(WIDTH-1)-1 when SIGNED_MODE=1, and 0/2^WIDTH-1 when SIGNED_MODE=0.
REQ-020 SWEEP SHALL assert o_valid every cycle, one sample per cycle, no gaps.
REQ-021 In SWEEP, b SHALL increment each cycle; when b=MAX, b wraps to MIN and a increments.
REQ-022 The sample a=MAX,b=MAX SHALL be the last one issued (2^(2*WIDTH) total); the FSM then enters DRAIN and o_valid drops.
REQ-023 An internal LATENCY-deep shift register SHALL carry the valid flag plus a,b, and qualify capture of i_exact/i_approx.
REQ-024 When LATENCY=0, capture SHALL be same-cycle combinational.
REQ-025 DRAIN SHALL last until the valid pipeline is empty (LATENCY cycles; 0 cycles when LATENCY=0), then go to DONE.
REQ-026 Products SHALL be interpreted per SIGNED_MODE; error SHALL be computed sign-extended in 2*WIDTH+1 bits; sums SHALL not overflow for any legal WIDTH.
REQ-027 Max tracking SHALL update only on strictly greater |error|, so the first occurrence is retained.
REQ-028 On a tie, o_max_a/o_max_b SHALL keep the earlier pair.
REQ-029 o_err_cnt SHALL increment when error is not equal to 0.
REQ-030 o_sample_cnt SHALL increment on every captured sample.
REQ-031 i_start in SWEEP or DRAIN SHALL be ignored.
REQ-032 DONE SHALL persist until i_start or i_rst; outputs SHALL hold constant in DONE.
REQ-033 Mean error and NMED (sum_abs / sample_cnt / max product) SHALL be computed off-block in software; no divider in RTL.

Reset
REQ-034 i_rst SHALL force IDLE and zero o_busy, o_done, o_valid, o_a, o_b, every accumulator/counter, and the valid pipeline, on the next edge.
REQ-035 i_rst SHALL dominate i_start.
REQ-036 i_rst mid-SWEEP or mid-DRAIN SHALL discard in-flight samples; no partial results are retained.

Structure
REQ-037 Package approx_err_pkg SHALL hold the FSM state enum and width helper functions (product, error, sum, count widths).
REQ-038 Sub-module err_accum SHALL hold the error datapath (subtract, abs, sums, max/argmax, counters), with clear and capture-enable inputs; the top holds the FSM, operand counters and valid pipeline.

Verification
REQ-039 WIDTH=2, SIGNED_MODE=1, approx tied to exact -> sample_cnt=16, all error outputs 0, err_cnt=0, max_a=max_b=0.
REQ-040 WIDTH=2, bench model approx=exact+1 -> sum_err=16, sum_abs_err=16, err_cnt=16, max_abs_err=1, max_a=max_b=-2.
REQ-041 WIDTH=8 with the log multiplier vs exact_mult, LATENCY 0 and 3 -> identical results, matching a software model; sample_cnt=65536; DONE reached 65536+LATENCY+1 cycles after i_start.
REQ-042 WIDTH=4, SIGNED_MODE=0 -> operand order 0..15 by 0..15 verified; last o_valid sample is (15,15).
REQ-043 i_start pulsed mid-SWEEP -> no restart, final counts unchanged; i_rst at sample 100 -> IDLE with all outputs 0 next cycle; a fresh i_start gives a clean full result.
REQ-044 i_start in DONE -> o_done falls and accumulators clear next cycle; second sweep results equal the first.
